// File: rtl/score_display_scan.sv
// score_display_scan
//   Scans four BCD score digits onto a 4-digit common-anode seven-segment
//   display, showing one digit per scan slot.
//   - The digits are captured once per frame, so a frame never mixes old and
//     new values.
//   - Leading zeros can be blanked.
//   - Each slot begins with an all-anodes-off guard so the previous digit's
//     segments do not ghost onto the next anode.
//   - While blink is high the whole display toggles every BLINK_FRAMES frames.
// Ports:
//   clk, reset_n          clock; asynchronous active-low reset
//   *_place [3:0]         BCD digits (units..thousands)
//   blank_lz              leading-zero blanking enable (sampled live)
//   blink                 blink whole display (game over)
//   an [3:0]              anode enables, active-low, an[0] = units
//   seg [6:0]             cathodes, active-low, {g,f,e,d,c,b,a}
//   frame_start           one-cycle pulse in the first cycle of a new snapshot
module score_display_scan #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] units_place,
  input  logic [3:0] tens_place,
  input  logic [3:0] hundreds_place,
  input  logic [3:0] thousands_place,
  input  logic       blank_lz,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] TICK_P    = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_P   = PW'(GUARD);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   snap_q, snap_d;   // [3]=thousands .. [0]=units
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              phase_q, phase_d;
  logic              fs_q, fs_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              tick;
  logic              blank;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = 7'b0111111;  // non-BCD shows a dash
    endcase
  endfunction

  always_comb begin
    tick    = (presc_q == TICK_P);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;

    // Capture on the last cycle of the thousands slot so the new frame
    // starts at index 0 with the fresh snapshot.
    snap_d = snap_q;
    fs_d   = 1'b0;
    if (tick && idx_q == 2'd3) begin
      snap_d = {thousands_place, hundreds_place, tens_place, units_place};
      fs_d   = 1'b1;
    end

    // Counter and phase are pinned to 0 while blink is low, so a fresh
    // blink request always opens with a visible half-period.
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!blink) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (fs_q) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // A digit is a leading zero only if it and every higher digit are 0.
    blank = 1'b0;
    case (idx_q)
      2'd3:    blank = (snap_q[3] == 4'd0);
      2'd2:    blank = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0);
      2'd1:    blank = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0) && (snap_q[1] == 4'd0);
      default: blank = 1'b0;
    endcase
    blank = blank && blank_lz;

    seg_d = blank ? 7'b1111111 : seg_enc(snap_q[idx_q]);
    an_d  = ~(4'b0001 << idx_q);
    if (presc_q < GUARD_P || (blink && phase_q))
      an_d = 4'b1111;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      fs_q    <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      fs_q    <= fs_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_score_display_scan.sv
// Bench for score_display_scan (SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2).
// A cycle-count model pushes the expected {an,seg,frame_start} on every
// rising edge; a checker pops and compares on every falling edge. Directed
// steps add literal checks for the main scenarios.
module tb_score_display_scan;
  localparam int SD = 8;
  localparam int GD = 2;
  localparam int BF = 2;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SD_ = 7'b0111111, SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] units = 4'd1, tens = 4'd2, hund = 4'd3, thou = 4'd4;
  logic       blank_lz = 1'b0, blink = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_start;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  score_display_scan #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset_n(reset_n),
    .units_place(units), .tens_place(tens),
    .hundreds_place(hund), .thousands_place(thou),
    .blank_lz(blank_lz), .blink(blink),
    .an(an), .seg(seg), .frame_start(frame_start)
  );

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return S0;  4'd1: return S1;  4'd2: return S2;  4'd3: return S3;
      4'd4: return S4;  4'd5: return S5;  4'd6: return S6;  4'd7: return S7;
      4'd8: return S8;  4'd9: return S9;
      default: return SD_;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model (cycles since reset release) --------
  int              m_cyc = 0;
  int              m_fc  = 0;
  logic            m_ph  = 1'b0;
  logic [3:0][3:0] m_snap = '0;
  int              m_p;
  logic [1:0]      m_i;
  logic            m_blank;
  logic            m_fs_state;
  exp_t            m_e;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_cyc = 0; m_fc = 0; m_ph = 1'b0; m_snap = '0;
      q.delete();
    end else begin
      m_p = m_cyc % SD;
      m_i = 2'((m_cyc / SD) % 4);
      m_fs_state = (m_cyc > 0) && (m_cyc % (4 * SD) == 0);
      case (m_i)
        2'd3:    m_blank = (m_snap[3] == 0);
        2'd2:    m_blank = (m_snap[3] == 0) && (m_snap[2] == 0);
        2'd1:    m_blank = (m_snap[3] == 0) && (m_snap[2] == 0) && (m_snap[1] == 0);
        default: m_blank = 1'b0;
      endcase
      m_blank  = m_blank && blank_lz;
      m_e.an   = (m_p < GD || (blink && m_ph)) ? 4'hF : 4'(~(4'b0001 << m_i));
      m_e.seg  = m_blank ? SB : enc(m_snap[m_i]);
      m_e.fs   = ((m_cyc + 1) % (4 * SD) == 0);
      q.push_back(m_e);
      if (!blink) begin
        m_fc = 0; m_ph = 1'b0;
      end else if (m_fs_state) begin
        if (m_fc == BF - 1) begin m_fc = 0; m_ph = ~m_ph; end
        else m_fc++;
      end
      if (m_p == SD - 1 && m_i == 2'd3) m_snap = {thou, hund, tens, units};
      m_cyc++;
    end
  end

  // ---------------- scoreboard checker -----------------------------------
  exp_t c_e;
  initial forever begin
    @(negedge clk);
    if (!reset_n || q.size() == 0) begin
      chk("reset_state", {an, seg, frame_start}, {4'hF, SB, 1'b0});
    end else begin
      c_e = q.pop_front();
      chk("scoreboard", {an, seg, frame_start}, c_e);
    end
  end

  // ---------------- directed helpers -------------------------------------
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    chk("frame_start_seen", {11'b0, frame_start}, 12'd1);
  endtask

  // Called at the falling edge where frame_start is seen; walks the frame.
  task automatic check_frame(input string tag, input logic [3:0][6:0] segs, input bit chg);
    int p, s;
    logic [3:0] ea;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (chg && k == 12) begin units = 4'd9; tens = 4'd8; hund = 4'd7; thou = 4'd6; end
      p  = (k - 1) % SD;
      s  = (k - 1) / SD;
      ea = (p < GD) ? 4'hF : 4'(~(4'b0001 << s));
      chk(tag, {an, seg, 1'b0}, {ea, segs[s], 1'b0});
    end
  endtask

  task automatic count_lit(output int n);
    n = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (an !== 4'hF) n++;
    end
  endtask

  int lit;

  initial begin
    #1 reset_n = 1'b0;
    #1 chk("in_reset", {an, seg, frame_start}, {4'hF, SB, 1'b0});
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    // First slot: snapshot is still 0000.
    @(negedge clk);
    chk("first_guard", {an, seg, 1'b0}, {4'hF, S0, 1'b0});
    repeat (3) @(negedge clk);
    chk("first_active", {an, seg, 1'b0}, {4'b1110, S0, 1'b0});

    // 1,2,3,4 with a mid-frame change that must wait for the next frame.
    wait_fs();
    check_frame("frame_1234", {S4, S3, S2, S1}, 1'b1);
    wait_fs();
    check_frame("frame_9876", {S6, S7, S8, S9}, 1'b0);

    // Leading-zero blanking.
    units = 4'd0; tens = 4'd0; hund = 4'd5; thou = 4'd0; blank_lz = 1'b1;
    wait_fs();
    check_frame("lz_0500", {SB, S5, S0, S0}, 1'b0);
    hund = 4'd0;
    wait_fs();
    check_frame("lz_0000", {SB, SB, SB, S0}, 1'b0);

    // Non-BCD digit shows a dash.
    units = 4'd3; tens = 4'hC;
    wait_fs();
    check_frame("dash", {SB, SB, SD_, S3}, 1'b0);

    // Blink: two lit frames, two dark frames, repeating.
    wait_fs();
    blink = 1'b1;
    wait_fs();
    count_lit(lit); chk("blink_dark_a", 12'(lit), 12'd0);
    count_lit(lit); chk("blink_dark_b", 12'(lit), 12'd0);
    count_lit(lit); chk("blink_lit_a",  12'(lit), 12'd24);
    count_lit(lit); chk("blink_lit_b",  12'(lit), 12'd24);
    repeat (13) @(negedge clk);   // into the dark half, mid-slot
    blink = 1'b0;
    repeat (20) @(negedge clk);

    // Asynchronous reset in the middle of slot 2.
    units = 4'd1; tens = 4'd2; hund = 4'd3; thou = 4'd4;
    wait_fs();
    repeat (1 + 2 * SD + 4) @(negedge clk);
    chk("pre_reset_slot2", {an, seg, 1'b0}, {4'b1011, S3, 1'b0});
    #2 reset_n = 1'b0;
    #1 chk("async_reset", {an, seg, frame_start}, {4'hF, SB, 1'b0});
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("restart_guard", {an, seg, 1'b0}, {4'hF, S0, 1'b0});
    repeat (3) @(negedge clk);
    chk("restart_units", {an, seg, 1'b0}, {4'b1110, S0, 1'b0});
    repeat (8) @(negedge clk);
    chk("restart_tens_blank", {an, seg, 1'b0}, {4'b1101, SB, 1'b0});
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
